// File: rtl/laser_tx_scheduler.sv
// ============================================================================
// laser_tx_scheduler
//
// Shares the single laser transmitter between the outbound data queue and the
// echo queue. One source is granted per frame with round-robin arbitration.
// The frame is header, length, up to MAX_PAYLOAD payload bytes popped from the
// granted queue, and an XOR checksum. Bytes go to the serializer over a
// valid/ready handshake.
//
// State     | Meaning
// ----------+-----------------------------------------------------------------
// IDLE      | no frame in flight; arbitrate when enabled and a queue has data
// HEADER    | offering DATA_HDR / ECHO_HDR of the granted source
// LENGTH    | offering the latched payload length
// PAYLOAD   | passing the granted queue head through, popping on each transfer
// CHECKSUM  | offering XOR of header, length and payload; frame count on accept
//
// Ports
//   clock        : sole clock, all state on posedge
//   reset        : synchronous active-low reset
//   enable       : gates the start of new frames only
//   data_q/_size/_empty, data_read : data queue head, count, empty, pop strobe
//   echo_q/_size/_empty, echo_read : echo queue head, count, empty, pop strobe
//   tx_data/tx_valid/tx_ready      : byte stream to the serializer
//   busy         : a frame is in flight
//   grant_echo   : source of the current or last frame (1 = echo)
//   frames_sent  : completed frame count, wraps at 16 bits
// ============================================================================
module laser_tx_scheduler #(
    parameter int unsigned MAX_PAYLOAD = 16,
    parameter logic [7:0]  DATA_HDR    = 8'hD7,
    parameter logic [7:0]  ECHO_HDR    = 8'hE5
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        enable,
    input  logic [7:0]  data_q,
    input  logic [7:0]  data_size,
    input  logic        data_empty,
    output logic        data_read,
    input  logic [7:0]  echo_q,
    input  logic [7:0]  echo_size,
    input  logic        echo_empty,
    output logic        echo_read,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        busy,
    output logic        grant_echo,
    output logic [15:0] frames_sent
);

    localparam logic [7:0] MAX_LEN = 8'(MAX_PAYLOAD);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HEADER,
        ST_LENGTH,
        ST_PAYLOAD,
        ST_CHECKSUM
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  len_q, len_d;
    logic [7:0]  remaining_q, remaining_d;
    logic [7:0]  csum_q, csum_d;
    logic [15:0] frames_sent_q, frames_sent_d;
    logic        grant_echo_q, grant_echo_d;
    logic        last_echo_q, last_echo_d;

    logic [7:0]  src_byte;
    logic        src_empty;
    logic        pick_echo;
    logic [7:0]  pick_size;
    logic [7:0]  pick_len;
    logic        any_ready;

    logic [7:0]  tx_data_int;
    logic        tx_valid_int;
    logic        rd_int;
    logic        xfer;

    // ------------------------------------------------------------------------
    // Source selection and arbitration
    // ------------------------------------------------------------------------
    always_comb begin
        src_byte  = grant_echo_q ? echo_q     : data_q;
        src_empty = grant_echo_q ? echo_empty : data_empty;
        any_ready = !data_empty || !echo_empty;

        // On a tie the source that did not win last time gets the frame.
        if (!data_empty && !echo_empty) begin
            pick_echo = !last_echo_q;
        end else begin
            pick_echo = !echo_empty;
        end

        pick_size = pick_echo ? echo_size : data_size;
        pick_len  = (pick_size > MAX_LEN) ? MAX_LEN : pick_size;
    end

    // ------------------------------------------------------------------------
    // Next-state and output logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d       = state_q;
        len_d         = len_q;
        remaining_d   = remaining_q;
        csum_d        = csum_q;
        frames_sent_d = frames_sent_q;
        grant_echo_d  = grant_echo_q;
        last_echo_d   = last_echo_q;
        tx_data_int   = 8'h00;
        tx_valid_int  = 1'b0;
        rd_int        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (enable && any_ready) begin
                    grant_echo_d = pick_echo;
                    last_echo_d  = pick_echo;
                    len_d        = pick_len;
                    remaining_d  = pick_len;
                    csum_d       = 8'h00;
                    state_d      = ST_HEADER;
                end
            end
            ST_HEADER: begin
                tx_data_int  = grant_echo_q ? ECHO_HDR : DATA_HDR;
                tx_valid_int = 1'b1;
            end
            ST_LENGTH: begin
                tx_data_int  = len_q;
                tx_valid_int = 1'b1;
            end
            ST_PAYLOAD: begin
                // Head byte passes straight through; an empty queue stalls
                // the frame rather than skipping a byte.
                tx_data_int  = src_byte;
                tx_valid_int = !src_empty;
            end
            ST_CHECKSUM: begin
                tx_data_int  = csum_q;
                tx_valid_int = 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A low reset masks the handshake in the same cycle so an abandoned
        // frame cannot pop one more byte on its way out.
        xfer = reset && tx_valid_int && tx_ready;

        if (xfer) begin
            case (state_q)
                ST_HEADER: begin
                    csum_d  = csum_q ^ tx_data_int;
                    state_d = ST_LENGTH;
                end
                ST_LENGTH: begin
                    csum_d  = csum_q ^ tx_data_int;
                    // A queue reporting non-empty with a zero count yields an
                    // empty frame rather than an unbounded payload.
                    state_d = (len_q == 8'h00) ? ST_CHECKSUM : ST_PAYLOAD;
                end
                ST_PAYLOAD: begin
                    rd_int      = 1'b1;
                    csum_d      = csum_q ^ tx_data_int;
                    remaining_d = remaining_q - 8'h01;
                    if (remaining_q == 8'h01) begin
                        state_d = ST_CHECKSUM;
                    end
                end
                ST_CHECKSUM: begin
                    frames_sent_d = frames_sent_q + 16'h0001;
                    state_d       = ST_IDLE;
                end
                default: begin
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            len_q         <= 8'h00;
            remaining_q   <= 8'h00;
            csum_q        <= 8'h00;
            frames_sent_q <= 16'h0000;
            grant_echo_q  <= 1'b0;
            last_echo_q   <= 1'b1;
        end else begin
            state_q       <= state_d;
            len_q         <= len_d;
            remaining_q   <= remaining_d;
            csum_q        <= csum_d;
            frames_sent_q <= frames_sent_d;
            grant_echo_q  <= grant_echo_d;
            last_echo_q   <= last_echo_d;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign tx_data     = tx_data_int;
    assign tx_valid    = reset && tx_valid_int;
    assign data_read   = rd_int && !grant_echo_q;
    assign echo_read   = rd_int && grant_echo_q;
    assign busy        = (state_q != ST_IDLE);
    assign grant_echo  = grant_echo_q;
    assign frames_sent = frames_sent_q;

endmodule
